// File: rtl/ahb_lite_master.sv
// ahb_lite_master: single-transfer AHB-lite initiator driven by a valid/ready
// command stream. Each accepted command becomes one NONSEQ SINGLE transfer and
// produces exactly one response pulse, in command order.
// Optional feature macro: AHB_LITE_MASTER_PIPELINE_EN. When it is defined, the
// next address phase may overlap the current data phase. When it is undefined,
// at most one transfer is outstanding.
// Handshake: a command transfers on a rising edge where CMD_VALID_I and
// CMD_READY_O are both 1. The caller holds the command fields stable while
// VALID is high. Responses cannot be stalled: RSP_VALID_O is a one-cycle pulse.
module ahb_lite_master #(
    parameter int         AW        = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic          HCLK_I,
    input  logic          HRESET_I,
    input  logic          CMD_VALID_I,
    output logic          CMD_READY_O,
    input  logic          CMD_WRITE_I,
    input  logic [2:0]    CMD_SIZE_I,
    input  logic [AW-1:0] CMD_ADDR_I,
    input  logic [31:0]   CMD_WDATA_I,
    output logic          RSP_VALID_O,
    output logic          RSP_ERR_O,
    output logic [31:0]   RSP_RDATA_O,
    output logic [AW-1:0] HADDR_O,
    output logic [1:0]    HTRANS_O,
    output logic          HWRITE_O,
    output logic [2:0]    HSIZE_O,
    output logic [2:0]    HBURST_O,
    output logic [3:0]    HPROT_O,
    output logic [31:0]   HWDATA_O,
    input  logic [31:0]   HRDATA_I,
    input  logic          HREADY_I,
    input  logic          HRESP_I,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    // ADDR: an address phase is on the bus (possibly overlapping a data phase,
    // flagged by dp_busy). DATA: only a data phase is in flight. ERR2: second
    // cycle of an ERROR response; held marks a cancelled command to reissue.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ERR2 = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          dp_busy, dp_busy_nxt;
    logic          held, held_nxt;
    logic [31:0]   a_wdata, a_wdata_nxt;
    logic          d_write, d_write_nxt;
    logic [AW-1:0] haddr_nxt;
    logic [1:0]    htrans_nxt;
    logic          hwrite_nxt;
    logic [2:0]    hsize_nxt;
    logic [31:0]   hwdata_nxt;
    logic          rsp_valid_nxt, rsp_err_nxt;
    logic [31:0]   rsp_rdata_nxt;
    logic          accept, done, done_err;

    assign HBURST_O  = 3'b000;
    assign HPROT_O   = HPROT_VAL;
    assign dbg_state = state;
    assign accept    = CMD_VALID_I & CMD_READY_O;

    // Command-side ready: only IDLE, or also when the current address phase ends.
    always_comb begin
`ifdef AHB_LITE_MASTER_PIPELINE_EN
        CMD_READY_O = !HRESET_I && ((state == IDLE) || ((state == ADDR) && HREADY_I));
`else
        CMD_READY_O = !HRESET_I && (state == IDLE);
`endif
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_nxt     = state;
        dp_busy_nxt   = dp_busy;
        held_nxt      = held;
        a_wdata_nxt   = a_wdata;
        d_write_nxt   = d_write;
        haddr_nxt     = HADDR_O;
        htrans_nxt    = HTRANS_O;
        hwrite_nxt    = HWRITE_O;
        hsize_nxt     = HSIZE_O;
        hwdata_nxt    = HWDATA_O;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = 32'h0;
        done          = 1'b0;
        done_err      = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    htrans_nxt  = TRANS_NONSEQ;
                    haddr_nxt   = CMD_ADDR_I;
                    hwrite_nxt  = CMD_WRITE_I;
                    hsize_nxt   = CMD_SIZE_I;
                    a_wdata_nxt = CMD_WDATA_I;
                    dp_busy_nxt = 1'b0;
                    state_nxt   = ADDR;
                end
            end
            ADDR: begin
                if (dp_busy && !HREADY_I && HRESP_I) begin
                    // Error on the overlapped data phase: withdraw the pending
                    // NONSEQ but keep its address/control for the reissue.
                    htrans_nxt  = TRANS_IDLE;
                    held_nxt    = 1'b1;
                    dp_busy_nxt = 1'b0;
                    state_nxt   = ERR2;
                end else if (HREADY_I) begin
                    done        = dp_busy;
                    done_err    = HRESP_I;
                    hwdata_nxt  = a_wdata;
                    d_write_nxt = HWRITE_O;
                    if (accept) begin
                        htrans_nxt  = TRANS_NONSEQ;
                        haddr_nxt   = CMD_ADDR_I;
                        hwrite_nxt  = CMD_WRITE_I;
                        hsize_nxt   = CMD_SIZE_I;
                        a_wdata_nxt = CMD_WDATA_I;
                        dp_busy_nxt = 1'b1;
                    end else begin
                        htrans_nxt  = TRANS_IDLE;
                        dp_busy_nxt = 1'b0;
                        state_nxt   = DATA;
                    end
                end
            end
            DATA: begin
                if (HREADY_I) begin
                    done      = 1'b1;
                    done_err  = HRESP_I;
                    state_nxt = IDLE;
                end else if (HRESP_I) begin
                    held_nxt  = 1'b0;
                    state_nxt = ERR2;
                end
            end
            ERR2: begin
                // Any HREADY here ends the transfer as an error, even if HRESP dropped.
                if (HREADY_I) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                    if (held) begin
                        htrans_nxt  = TRANS_NONSEQ;
                        held_nxt    = 1'b0;
                        dp_busy_nxt = 1'b0;
                        state_nxt   = ADDR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (done) begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = done_err;
            rsp_rdata_nxt = (!done_err && !d_write) ? HRDATA_I : 32'h0;
        end
    end

    // State and registered outputs; reset abandons any transfer in flight.
    always_ff @(posedge HCLK_I) begin
        if (HRESET_I) begin
            state       <= IDLE;
            dp_busy     <= 1'b0;
            held        <= 1'b0;
            a_wdata     <= 32'h0;
            d_write     <= 1'b0;
            HADDR_O     <= '0;
            HTRANS_O    <= TRANS_IDLE;
            HWRITE_O    <= 1'b0;
            HSIZE_O     <= 3'b000;
            HWDATA_O    <= 32'h0;
            RSP_VALID_O <= 1'b0;
            RSP_ERR_O   <= 1'b0;
            RSP_RDATA_O <= 32'h0;
        end else begin
            state       <= state_nxt;
            dp_busy     <= dp_busy_nxt;
            held        <= held_nxt;
            a_wdata     <= a_wdata_nxt;
            d_write     <= d_write_nxt;
            HADDR_O     <= haddr_nxt;
            HTRANS_O    <= htrans_nxt;
            HWRITE_O    <= hwrite_nxt;
            HSIZE_O     <= hsize_nxt;
            HWDATA_O    <= hwdata_nxt;
            RSP_VALID_O <= rsp_valid_nxt;
            RSP_ERR_O   <= rsp_err_nxt;
            RSP_RDATA_O <= rsp_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed and randomized bench for ahb_lite_master with a
// behavioural AHB slave and a command/response scoreboard.
module tb_ahb_lite_master;

    localparam int AW = 32;
`ifdef AHB_LITE_MASTER_PIPELINE_EN
    localparam int SPACING = 1;
    localparam int ERR_GAP = 3;
`else
    localparam int SPACING = 3;
    localparam int ERR_GAP = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [2:0]    cmd_size;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize, hburst;
    logic [3:0]    hprot;
    logic [31:0]   hwdata, hrdata;
    logic          hready, hresp;
    logic [1:0]    dbg_state;

    ahb_lite_master #(.AW(AW), .HPROT_VAL(4'b0011)) dut (
        .HCLK_I(clk), .HRESET_I(rst),
        .CMD_VALID_I(cmd_valid), .CMD_READY_O(cmd_ready), .CMD_WRITE_I(cmd_write),
        .CMD_SIZE_I(cmd_size), .CMD_ADDR_I(cmd_addr), .CMD_WDATA_I(cmd_wdata),
        .RSP_VALID_O(rsp_valid), .RSP_ERR_O(rsp_err), .RSP_RDATA_O(rsp_rdata),
        .HADDR_O(haddr), .HTRANS_O(htrans), .HWRITE_O(hwrite), .HSIZE_O(hsize),
        .HBURST_O(hburst), .HPROT_O(hprot), .HWDATA_O(hwdata), .HRDATA_I(hrdata),
        .HREADY_I(hready), .HRESP_I(hresp), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int rsp_count = 0;

    // Scoreboard queues: responses {err, rdata}, address phases
    // {write, size, addr, wdata}, slave plans {waits, err, rdata}.
    logic [32:0] exp_q[$];
    logic [67:0] exp_a_q[$];
    logic [36:0] plan_q[$];
    int unsigned ns_cyc[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_model(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                              input logic [31:0] wd, input int waits, input logic err,
                              input logic [31:0] rd);
        exp_a_q.push_back({wr, sz, addr, wd});
        plan_q.push_back({4'(waits), err, rd});
        exp_q.push_back({err, (err || wr) ? 32'h0 : rd});
    endtask

    // Drive one command and return right after the edge that accepts it.
    task automatic send_cmd(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, input int waits, input logic err,
                            input logic [31:0] rd);
        int n;
        push_model(wr, sz, addr, wd, waits, err, rd);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_size  = sz;
        cmd_addr  = addr;
        cmd_wdata = wd;
        #1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("accept_wait", n < 200, 1);
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    // After an accept: check the NONSEQ cycle and the single response pulse.
    task automatic watch_rsp(input string tag, input logic [31:0] addr, input logic wr,
                             input int at, input int span);
        for (int i = 1; i <= span; i++) begin
            @(negedge clk);
            if (i == 1) begin
                cmd_valid = 1'b0;
                check_eq({tag, "_nonseq"}, htrans, 2'b10);
                check_eq({tag, "_haddr"}, haddr, addr);
                check_eq({tag, "_hwrite"}, hwrite, wr);
            end
            check_eq({tag, "_rsp_valid"}, rsp_valid, (i == at));
        end
    endtask

    // Behavioural slave plus bus and response monitors.
    bit          s_dp = 0;
    int          s_k = 0, s_waits = 0;
    bit          s_err = 0;
    logic [31:0] s_rdata = 0, s_wdata = 0;
    logic        s_wr = 0;
    bit          smp_rst, smp_addr_done, smp_dp_done;
    bit          prev_hold = 0;
    logic [31:0] prev_addr = 0;

    initial begin : bus_model
        logic [67:0] a;
        logic [36:0] p;
        logic        n_wr;
        logic [31:0] n_wd;
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = 32'h0;
        a = '0; p = '0; n_wr = 1'b0; n_wd = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            smp_rst = rst;
            check_eq("htrans_legal", (htrans == 2'b00) || (htrans == 2'b10), 1);
            if (prev_hold) begin
                check_eq("addr_hold_trans", htrans, 2'b10);
                check_eq("addr_hold_addr", haddr, prev_addr);
            end
            prev_hold = !smp_rst && (htrans == 2'b10) && !hready && !hresp;
            prev_addr = haddr;
            smp_dp_done = s_dp && hready;
            if (smp_dp_done && s_wr) check_eq("hwdata", hwdata, s_wdata);
            if (s_dp && s_err && (s_k == s_waits + 1)) check_eq("err2_idle", htrans, 2'b00);
            smp_addr_done = !smp_rst && (htrans == 2'b10) && hready;
            if (smp_addr_done) begin
                ns_cyc.push_back(cyc);
                if (exp_a_q.size() == 0) begin
                    check_eq("addr_unexpected", 1, 0);
                end else begin
                    a = exp_a_q.pop_front();
                    check_eq("haddr", haddr, a[63:32]);
                    check_eq("hwrite", hwrite, a[67]);
                    check_eq("hsize", hsize, a[66:64]);
                    n_wr = a[67];
                    n_wd = a[31:0];
                end
                p = (plan_q.size() != 0) ? plan_q.pop_front() : 37'h0;
            end
            if (rsp_valid) begin
                rsp_count++;
                if (exp_q.size() == 0) check_eq("rsp_unexpected", 1, 0);
                else check_eq("rsp", {rsp_err, rsp_rdata}, exp_q.pop_front());
            end
            @(posedge clk);
            #1;
            if (smp_rst) begin
                s_dp = 0;
            end else begin
                if (smp_dp_done) s_dp = 0;
                else if (s_dp) s_k++;
                if (smp_addr_done) begin
                    s_dp = 1;
                    s_k = 0;
                    s_waits = int'(p[36:33]);
                    s_err = p[32];
                    s_rdata = p[31:0];
                    s_wr = n_wr;
                    s_wdata = n_wd;
                end
            end
            hrdata = $urandom;
            if (!s_dp) begin hready = 1; hresp = 0; end
            else if (s_k < s_waits) begin hready = 0; hresp = 0; end
            else if (!s_err) begin hready = 1; hresp = 0; hrdata = s_rdata; end
            else if (s_k == s_waits) begin hready = 0; hresp = 1; end
            else begin hready = 1; hresp = 1; end
        end
    end

    // Global time bound.
    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Main sequence.
    initial begin
        int base_rsp;
        int n;
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_size  = 3'd2;
        cmd_addr  = 32'h10;
        cmd_wdata = 32'h1234;

        // Reset held 3 cycles with a command waiting.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_htrans", htrans, 2'b00);
            check_eq("rst_ready", cmd_ready, 0);
            check_eq("rst_rsp_valid", rsp_valid, 0);
            check_eq("rst_haddr", haddr, 0);
        end
        rst = 1'b0;
        push_model(1'b1, 3'd2, 32'h10, 32'h1234, 0, 1'b0, 32'h0);
        #1;
        check_eq("ready_after_rst", cmd_ready, 1);
        @(posedge clk);
        idle_cycles(5);

        // Zero-wait write: NONSEQ at N+1, response at N+3.
        send_cmd(1'b1, 3'd2, 32'h104, 32'h41, 0, 1'b0, 32'h0);
        watch_rsp("wr", 32'h104, 1'b1, 3, 4);

        // Read with two wait states.
        send_cmd(1'b0, 3'd2, 32'h200, 32'h0, 2, 1'b0, 32'hDEADBEEF);
        watch_rsp("rd_wait", 32'h200, 1'b0, 5, 6);

        // Two-cycle ERROR response on a write.
        send_cmd(1'b1, 3'd2, 32'h300, 32'h55, 0, 1'b1, 32'h0);
        watch_rsp("wr_err", 32'h300, 1'b1, 4, 5);
        idle_cycles(2);

        // Four back-to-back zero-wait writes.
        ns_cyc.delete();
        base_rsp = rsp_count;
        for (int i = 0; i < 4; i++)
            send_cmd(1'b1, 3'd2, 32'(i * 4), 32'hA0 + 32'(i), 0, 1'b0, 32'h0);
        idle_cycles(14);
        check_eq("b2b_count", ns_cyc.size(), 4);
        check_eq("b2b_rsp_count", rsp_count - base_rsp, 4);
        if (ns_cyc.size() == 4)
            for (int i = 1; i < 4; i++)
                check_eq("b2b_spacing", ns_cyc[i] - ns_cyc[i-1], SPACING);

        // Error on the first of two queued writes.
        ns_cyc.delete();
        send_cmd(1'b1, 3'd2, 32'h400, 32'h11, 0, 1'b1, 32'h0);
        send_cmd(1'b1, 3'd2, 32'h404, 32'h22, 0, 1'b0, 32'h0);
        idle_cycles(14);
        check_eq("err_pair_count", ns_cyc.size(), 2);
        if (ns_cyc.size() == 2) check_eq("err_pair_gap", ns_cyc[1] - ns_cyc[0], ERR_GAP);

        // Reset while the data phase is stalled.
        send_cmd(1'b0, 3'd2, 32'h500, 32'h0, 5, 1'b0, 32'hCAFEF00D);
        idle_cycles(2);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        exp_a_q.delete();
        plan_q.delete();
        @(negedge clk);
        check_eq("mid_rst_htrans", htrans, 2'b00);
        check_eq("mid_rst_haddr", haddr, 0);
        check_eq("mid_rst_hwrite", hwrite, 0);
        check_eq("mid_rst_hsize", hsize, 0);
        check_eq("mid_rst_hwdata", hwdata, 0);
        check_eq("mid_rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        check_eq("mid_rst_ready", cmd_ready, 0);
        rst = 1'b0;
        idle_cycles(8);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            logic [2:0] sz;
            sz = ($urandom_range(0, 9) > 7) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            idle_cycles($urandom_range(0, 2));
            send_cmd(1'($urandom_range(0, 1)), sz, $urandom, $urandom,
                     $urandom_range(0, 3), ($urandom_range(0, 5) == 0), $urandom);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            n++;
        end
        idle_cycles(4);
        check_eq("drain_rsp", exp_q.size(), 0);
        check_eq("drain_addr", exp_a_q.size(), 0);
        check_eq("hburst", hburst, 3'b000);
        check_eq("hprot", hprot, 4'b0011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- AHB-lite initiator: turns a simple valid/ready command stream into single AHB transfers and returns one response per command.
- Drives the same bus our AHB responders (sim control, memories) sit on, so CPU-less benches and DMA-style helpers can generate real bus traffic.
- Issues single transfers only (HBURST = SINGLE). Responses come back in command order.

Parameters:
- AW, 32, address width (HADDR_O width).
- HPROT_VAL, 4'b0011, constant driven on HPROT_O (non-cacheable privileged data).

Ports:
- HCLK_I  in  1  bus clock; all logic on rising edge.
- HRESET_I  in  1  synchronous, active-high reset.
- CMD_VALID_I  in  1  command present.
- CMD_READY_O  out  1  command accepted when VALID & READY.
- CMD_WRITE_I  in  1  1 = write, 0 = read.
- CMD_SIZE_I  in  3  HSIZE encoding; only 0/1/2 are legal.
- CMD_ADDR_I  in  AW  byte address.
- CMD_WDATA_I  in  32  write data, already lane-aligned by the caller.
- RSP_VALID_O  out  1  one-cycle response pulse; there is no backpressure.
- RSP_ERR_O  out  1  slave returned ERROR; valid with RSP_VALID_O.
- RSP_RDATA_O  out  32  read data; valid with RSP_VALID_O for reads, 0 for writes.
- HADDR_O  out  AW  AHB address.
- HTRANS_O  out  2  IDLE = 2'b00 or NONSEQ = 2'b10 only.
- HWRITE_O  out  1  AHB write.
- HSIZE_O  out  3  AHB size.
- HBURST_O  out  3  constant 3'b000.
- HPROT_O  out  4  constant HPROT_VAL.
- HWDATA_O  out  32  write data, driven during the data phase.
- HRDATA_I  in  32  read data.
- HREADY_I  in  1  bus ready.
- HRESP_I  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (HRESET_I high at a clock edge): HTRANS_O=IDLE, HADDR_O=0, HWRITE_O=0, HSIZE_O=0, HWDATA_O=0, RSP_VALID_O=0, RSP_ERR_O=0, RSP_RDATA_O=0, CMD_READY_O=0 during reset. State returns to IDLE.
- Reset mid-transfer: the outstanding transfer is abandoned and produces no response.
- All bus outputs are registered.
- Address-phase state: ADDR.
  - HTRANS_O=NONSEQ with address/control from the accepted command.
  - Held stable while HREADY_I=0.
  - Phase ends on the first edge with HREADY_I=1.
- Data-phase state: DATA.
  - HWDATA_O holds the write data; HTRANS_O=IDLE unless the next address is pipelined (see Optional Feature).
  - HREADY_I=1 & HRESP_I=0: OKAY completion. RDATA is captured from HRDATA_I.
  - HREADY_I=0 & HRESP_I=1: first error cycle; go to state ERR2 and force HTRANS_O=IDLE next cycle.
- ERR2 state: waits for HREADY_I=1 & HRESP_I=1, then completes with an error.
  - HREADY_I=1 with HRESP_I=0 in ERR2 is a protocol violation; treat it as error completion.
- Completion: RSP_VALID_O=1 for exactly one cycle, on the cycle after the completing edge. RSP_ERR_O follows. RSP_RDATA_O=0 on writes and on errors.
- State list: IDLE, ADDR, DATA, ERR2.
  - IDLE -> ADDR on command accept.
  - ADDR -> DATA on HREADY_I.
  - DATA -> IDLE or ADDR on OKAY completion; -> ERR2 on first error cycle.
  - ERR2 -> IDLE or ADDR on completion.
- Latency, zero-wait slave: command accepted at cycle N, NONSEQ at N+1, data phase N+2, RSP_VALID_O at N+3.
- CMD_SIZE_I > 2: still issued as given; the size check is left to the caller.
- Unaligned addresses: passed through unmodified.

Optional Feature:
- Macro: AHB_LITE_MASTER_PIPELINE_EN.
- Defined:
  - CMD_READY_O=1 in IDLE, and also when the current address phase completes this cycle (state ADDR & HREADY_I).
  - The next NONSEQ is driven during the previous transfer's data phase; zero-wait throughput is 1 transfer/cycle.
  - On an ERROR first cycle, a pending NONSEQ is replaced by IDLE. The cancelled command is kept and reissued as NONSEQ after ERR2 completes.
  - Response order is preserved and every accepted command gets exactly one response.
- Undefined:
  - CMD_READY_O=1 only in IDLE.
  - One outstanding transfer; HTRANS_O=IDLE in every cycle outside ADDR.
  - Zero-wait throughput is 1 transfer per 3 cycles.

Test Plan:
- Reset held 3 cycles with CMD_VALID_I=1 -> HTRANS_O=00, CMD_READY_O=0, RSP_VALID_O=0 throughout; first accept on the cycle after reset deasserts.
- Write addr 0x104, data 0x41, size 2, zero-wait slave -> NONSEQ at N+1 with HADDR_O=0x104, HWRITE_O=1; HWDATA_O=0x41 at N+2; RSP_VALID_O=1, RSP_ERR_O=0 at N+3.
- Read addr 0x200, slave inserts 2 wait states then returns 0xDEADBEEF -> address/data held stable during the waits; RSP_RDATA_O=0xDEADBEEF, RSP_VALID_O one cycle only.
- Slave ERROR response (HREADY 0/HRESP 1, then HREADY 1/HRESP 1) on a write to 0x300 -> HTRANS_O=IDLE in the 2nd error cycle; RSP_ERR_O=1, RSP_RDATA_O=0.
- PIPELINE_EN, 4 back-to-back writes to 0x0, 0x4, 0x8, 0xC with zero wait -> NONSEQ on 4 consecutive cycles; 4 RSP_VALID_O pulses in order. Without the macro -> NONSEQs 3 cycles apart.
- PIPELINE_EN, error on the 1st of 2 queued writes -> 2nd address replaced by IDLE, then reissued after ERR2; responses are err=1 then err=0.
- HRESET_I asserted while in DATA with HREADY_I=0 -> no RSP_VALID_O; next cycle all outputs are at reset values.
